// File: rtl/exc_ctrl.sv
// MEM-stage exception arbiter: picks the highest-priority exception, pulses it to CP0,
// then flushes the pipeline for FLUSH_CYCLES cycles and issues one PC redirect at the end.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [4:0]  mem_exc_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic        new_pc_valid_o,
  output logic [31:0] new_pc_o
);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [4:0]  r_code;
  logic [31:0] r_pc, r_target, r_new_pc;
  logic        r_ds;

  logic [31:0] w_status, w_cause, w_epc;
  logic        w_int, w_capture;
  logic [4:0]  w_code;
  logic        w_unused;

  // CP0 writes still sitting in WB must be seen by this cycle's decision.
  always_comb begin
    w_status = cp0_status_i;
    w_cause  = cp0_cause_i;
    w_epc    = cp0_epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) w_status = wb_cp0_wdata_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) begin
      w_cause[9:8]   = wb_cp0_wdata_i[9:8];
      w_cause[23:22] = wb_cp0_wdata_i[23:22];
    end
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) w_epc = wb_cp0_wdata_i;
  end

  assign w_int    = w_status[0] & ~w_status[1] & (|(w_cause[15:8] & w_status[15:8]));
  assign w_unused = ^{w_status, w_cause};

  always_comb begin
    w_code = 5'h00;
    if (!mem_valid_i)      w_code = 5'h00;
    else if (w_int)        w_code = 5'h01;
    else if (mem_exc_i[0]) w_code = 5'h08;
    else if (mem_exc_i[1]) w_code = 5'h0a;
    else if (mem_exc_i[2]) w_code = 5'h0d;
    else if (mem_exc_i[3]) w_code = 5'h0c;
    else if (mem_exc_i[4]) w_code = 5'h0e;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_cnt_nxt           = r_cnt;
    w_capture           = 1'b0;
    flush_o             = 1'b0;
    new_pc_valid_o      = 1'b0;
    new_pc_o            = r_new_pc;
    excepttype_o        = 32'h0;
    current_inst_addr_o = 32'h0;
    is_in_delayslot_o   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_code != 5'h00) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush_o = 1'b1;
        if (r_cnt == CNT_INIT) begin
          excepttype_o        = {27'h0, r_code};
          current_inst_addr_o = r_pc;
          is_in_delayslot_o   = r_ds;
        end
        if (r_cnt == 4'd0) begin
          new_pc_valid_o = 1'b1;
          new_pc_o       = r_target;
          w_state_nxt    = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= 4'd0;
      r_code   <= 5'h00;
      r_pc     <= 32'h0;
      r_ds     <= 1'b0;
      r_target <= 32'h0;
      r_new_pc <= 32'h0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_capture) begin
        r_code   <= w_code;
        r_pc     <= mem_pc_i;
        r_ds     <= mem_in_delayslot_i;
        r_target <= (w_code == 5'h0e) ? w_epc : EXC_VECTOR;
      end
      // Remember the last redirect so new_pc_o holds between pulses.
      if (new_pc_valid_o) r_new_pc <= r_target;
    end
  end

endmodule
